fir_mac_sched: RTL and testbench

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

---
 rtl/fir_mac_sched.sv | 140 ++++++++++++++
 tb/tb_fir_mac_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sched.sv
// Control scheduler for a shared-MAC FIR: flushes the delay line, writes each new
// sample, walks all taps through one MAC and flags when the accumulator is final.
module fir_mac_sched #(
  parameter int NTAP    = 16,
  parameter int AW      = 4,
  parameter int MAC_LAT = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          din_valid,
  input  logic          ovr_clr,
  output logic          din_ready,
  output logic          wr_en,
  output logic          wr_zero,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          acc_done,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [AW-1:0] K_LAST = AW'(NTAP - 1);
  localparam logic [3:0]    D_LAST = 4'(MAC_LAT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] newest_q, newest_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic          overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wr_ptr_d  = wr_ptr_q;
    newest_d  = newest_q;
    dcnt_d    = dcnt_q;
    din_ready = 1'b0;
    wr_en     = 1'b0;
    wr_zero   = 1'b0;
    wr_addr   = '0;
    rd_addr   = '0;
    coef_addr = '0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    acc_done  = 1'b0;

    case (state_q)
      S_INIT: begin
        wr_en   = 1'b1;
        wr_zero = 1'b1;
        wr_addr = k_q;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d  = S_IDLE;
          k_d      = '0;
          wr_ptr_d = '0;
        end
      end
      S_IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          wr_en    = 1'b1;
          wr_addr  = wr_ptr_q;
          newest_d = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + 1'b1;
          k_d      = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Tap k pairs coefficient k with the sample k positions older than newest.
        mac_en    = 1'b1;
        coef_addr = k_q;
        rd_addr   = newest_q - k_q;
        mac_clr   = (k_q == '0);
        k_d       = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          k_d     = '0;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == D_LAST) begin
          acc_done = 1'b1;
          dcnt_d   = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Reset holds every strobe low even though the state register is only cleared at the edge.
    if (sys_rst) begin
      din_ready = 1'b0;
      wr_en     = 1'b0;
      wr_zero   = 1'b0;
      wr_addr   = '0;
      rd_addr   = '0;
      coef_addr = '0;
      mac_en    = 1'b0;
      mac_clr   = 1'b0;
      acc_done  = 1'b0;
    end

    busy = sys_rst || (state_q != S_IDLE);

    if (din_valid && !din_ready) overrun_d = 1'b1;
    else if (ovr_clr)            overrun_d = 1'b0;
    else                         overrun_d = overrun_q;
  end

  assign overrun = overrun_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_INIT;
      k_q       <= '0;
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      dcnt_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wr_ptr_q  <= wr_ptr_d;
      newest_q  <= newest_d;
      dcnt_q    <= dcnt_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Scoreboard bench for fir_mac_sched: expected strobe events are queued by the
// stimulus and consumed by an independent monitor on the falling edge.
module tb_fir_mac_sched;

  logic       sys_clk = 1'b0;
  logic       sys_rst, din_valid, ovr_clr, din_valid1;
  logic       din_ready, wr_en, wr_zero, mac_en, mac_clr, acc_done, busy, overrun;
  logic [3:0] wr_addr, rd_addr, coef_addr;
  logic       din_ready1, wr_en1, wr_zero1, mac_en1, mac_clr1, acc_done1, busy1, overrun1;
  logic [3:0] wr_addr1, rd_addr1, coef_addr1;

  typedef struct packed {
    logic [1:0]  kind;   // 0 write, 1 mac, 2 done
    logic [3:0]  addr;
    logic [3:0]  coef;
    logic        flag;   // wr_zero or mac_clr
    logic [31:0] cyc;
  } ev_t;

  ev_t        sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] exp_ptr;

  fir_mac_sched #(.NTAP(16), .AW(4), .MAC_LAT(2)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .din_valid(din_valid), .ovr_clr(ovr_clr),
    .din_ready(din_ready), .wr_en(wr_en), .wr_zero(wr_zero), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .coef_addr(coef_addr), .mac_en(mac_en), .mac_clr(mac_clr),
    .acc_done(acc_done), .busy(busy), .overrun(overrun)
  );

  fir_mac_sched #(.NTAP(16), .AW(4), .MAC_LAT(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .din_valid(din_valid1), .ovr_clr(ovr_clr),
    .din_ready(din_ready1), .wr_en(wr_en1), .wr_zero(wr_zero1), .wr_addr(wr_addr1),
    .rd_addr(rd_addr1), .coef_addr(coef_addr1), .mac_en(mac_en1), .mac_clr(mac_clr1),
    .acc_done(acc_done1), .busy(busy1), .overrun(overrun1)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc = cyc + 1;

  always @(negedge sys_clk) begin : monitor
    ev_t act, expv;
    if (wr_en || mac_en || acc_done) begin
      act = '0;
      act.cyc = 32'(cyc);
      if (wr_en) begin
        act.kind = 2'd0; act.addr = wr_addr; act.flag = wr_zero;
      end else if (mac_en) begin
        act.kind = 2'd1; act.addr = rd_addr; act.coef = coef_addr; act.flag = mac_clr;
      end else begin
        act.kind = 2'd2;
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d kind=%0d addr=%0d, none required", cyc, act.kind, act.addr);
      end else begin
        expv = sb.pop_front();
        if (act !== expv) begin
          failures++;
          $display("FAIL event got kind=%0d addr=%0d coef=%0d flag=%0d cyc=%0d, required kind=%0d addr=%0d coef=%0d flag=%0d cyc=%0d",
                   act.kind, act.addr, act.coef, act.flag, act.cyc,
                   expv.kind, expv.addr, expv.coef, expv.flag, expv.cyc);
        end
      end
    end
    checks++;
    if ((!wr_en && (wr_addr != 4'd0 || wr_zero)) ||
        (!mac_en && (rd_addr != 4'd0 || coef_addr != 4'd0 || mac_clr)) ||
        ($countones({wr_en, mac_en, acc_done}) > 1)) begin
      failures++;
      $display("FAIL idle_outputs cyc=%0d wr=%b/%0d/%b mac=%b/%0d/%0d/%b done=%b, required inactive fields 0",
               cyc, wr_en, wr_addr, wr_zero, mac_en, rd_addr, coef_addr, mac_clr, acc_done);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d cyc=%0d", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [3:0] addr, input logic [3:0] coef,
                      input logic flag, input int c);
    ev_t e;
    e.kind = kind; e.addr = addr; e.coef = coef; e.flag = flag; e.cyc = 32'(c);
    sb.push_back(e);
  endtask

  task automatic expect_init(input int t0);
    for (int i = 0; i < 16; i++) push(2'd0, 4'(i), 4'd0, 1'b1, t0 + i);
  endtask

  task automatic expect_sample(input int t, input logic [3:0] ptr, input int nmac, input bit done);
    logic [3:0] a;
    push(2'd0, ptr, 4'd0, 1'b0, t);
    for (int k = 0; k < nmac; k++) begin
      a = ptr - 4'(k);
      push(2'd1, a, 4'(k), (k == 0), t + 1 + k);
    end
    if (done) push(2'd2, 4'd0, 4'd0, 1'b0, t + 18);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!din_ready && n < 40) begin
      tick();
      n++;
    end
    chk("ready_timeout", {31'd0, din_ready}, 1);
  endtask

  task automatic send(output int t);
    din_valid = 1'b1;
    t = cyc;
    expect_sample(t, exp_ptr, 16, 1'b1);
    exp_ptr = exp_ptr + 4'd1;
    tick();
    din_valid = 1'b0;
  endtask

  initial begin
    int r, t, tprev;
    sys_rst = 1'b1; din_valid = 1'b0; ovr_clr = 1'b0; din_valid1 = 1'b0; exp_ptr = 4'd0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, din_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_overrun", {31'd0, overrun}, 0);

    sys_rst = 1'b0;
    r = cyc;
    expect_init(r);
    wait_ready();
    chk("init_len", 32'(cyc - r), 16);

    // 17 back-to-back samples: write pointer wraps on the last one
    tprev = 0;
    for (int i = 0; i < 17; i++) begin
      wait_ready();
      if (i > 0) chk("ready_gap", 32'(cyc - tprev), 19);
      send(t);
      tprev = t;
      chk("run_busy", {31'd0, busy}, 1);
      chk("run_ready", {31'd0, din_ready}, 0);
    end

    // Overrun: drop in RUN, clear, set-wins-over-clear, clear
    wait_ready();
    send(t);
    tick();
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("ovr_set", {31'd0, overrun}, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 0);
    din_valid = 1'b1; ovr_clr = 1'b1;
    tick();
    din_valid = 1'b0; ovr_clr = 1'b0;
    chk("ovr_set_wins", {31'd0, overrun}, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr_again", {31'd0, overrun}, 0);

    // Reset during RUN at tap 7 aborts without acc_done and reflushes
    wait_ready();
    din_valid = 1'b1;
    t = cyc;
    expect_sample(t, exp_ptr, 7, 1'b0);
    tick();
    din_valid = 1'b0;
    repeat (7) tick();
    sys_rst = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 1);
    chk("abort_ready", {31'd0, din_ready}, 0);
    sys_rst = 1'b0;
    r = cyc;
    expect_init(r);
    exp_ptr = 4'd0;
    wait_ready();
    chk("reinit_len", 32'(cyc - r), 16);
    send(t);
    wait_ready();
    tick();
    chk("sb_empty", 32'(sb.size()), 0);

    // MAC_LAT=1 instance: done one cycle earlier, ready right after
    din_valid1 = 1'b1;
    t = cyc;
    tick();
    din_valid1 = 1'b0;
    while (!acc_done1 && (cyc - t) < 30) tick();
    chk("lat1_done", 32'(cyc - t), 17);
    chk("lat1_ready_lo", {31'd0, din_ready1}, 0);
    tick();
    chk("lat1_ready", {31'd0, din_ready1}, 1);
    chk("lat1_quiet", {13'd0, wr_en1, wr_zero1, wr_addr1, rd_addr1, coef_addr1,
                       mac_en1, mac_clr1, acc_done1, busy1, overrun1}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d, required completion", cyc);
    $fatal(1);
  end

endmodule
